// File: rtl/mmcm_drp_pkg.sv
// mmcm_drp_pkg: shared types and constants for the MMCM DRP reconfiguration
// sequencer and its entry table.
package mmcm_drp_pkg;

  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    RST_ON,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    NEXT,
    LOCK_WAIT
  } state_t;

  typedef struct packed {
    logic [DRP_ADDR_W-1:0] addr;
    logic [DRP_DATA_W-1:0] mask;
    logic [DRP_DATA_W-1:0] data;
  } drp_entry_t;

  // Index width for a table of n entries; a one-entry table still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmcm_drp_reconfig_if.sv
// mmcm_drp_reconfig_if: DRP port plus MMCM reset/lock between the sequencer
// (master) and the MMCME2_ADV primitive (slave).
interface mmcm_drp_reconfig_if
  import mmcm_drp_pkg::*;
();

  logic [DRP_ADDR_W-1:0] daddr;
  logic [DRP_DATA_W-1:0] di;
  logic                  den;
  logic                  dwe;
  logic [DRP_DATA_W-1:0] do_i;
  logic                  drdy;
  logic                  mmcm_rst;
  logic                  locked;

  modport master (
    output daddr, di, den, dwe, mmcm_rst,
    input  do_i, drdy, locked
  );

  modport slave (
    input  daddr, di, den, dwe, mmcm_rst,
    output do_i, drdy, locked
  );

endinterface

// File: rtl/mmcm_drp_table.sv
// mmcm_drp_table: combinational ROM of DRP read-modify-write entries,
// indexed by the sequencer's tbl_idx. Unused slots keep every bit (mask all ones).
module mmcm_drp_table
  import mmcm_drp_pkg::*;
#(
  parameter  int NUM_ENTRIES = 8,
  localparam int IDX_W       = idx_width(NUM_ENTRIES)
) (
  input  logic [IDX_W-1:0] idx,
  output drp_entry_t       entry
);

  logic [4:0] w_idx;

  assign w_idx = 5'(idx);

  // Entry lookup.
  // NOTE: this is a constant ROM with no storage, so there is nothing to reset.
  always_comb begin
    entry = '{addr: '0, mask: 16'hFFFF, data: '0};
    case (w_idx)
      5'd0:    entry = '{addr: 7'h08, mask: 16'h1000, data: 16'h0041};
      5'd1:    entry = '{addr: 7'h09, mask: 16'hFC00, data: 16'h0000};
      5'd2:    entry = '{addr: 7'h14, mask: 16'h1000, data: 16'h0145};
      5'd3:    entry = '{addr: 7'h15, mask: 16'hFC00, data: 16'h0000};
      5'd4:    entry = '{addr: 7'h16, mask: 16'hC000, data: 16'h0041};
      5'd5:    entry = '{addr: 7'h18, mask: 16'hFC00, data: 16'h03E8};
      5'd6:    entry = '{addr: 7'h19, mask: 16'h8000, data: 16'h7C01};
      5'd7:    entry = '{addr: 7'h4E, mask: 16'h66FF, data: 16'h9900};
      default: entry = '{addr: '0, mask: 16'hFFFF, data: '0};
    endcase
  end

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// mmcm_drp_reconfig: DRP read-modify-write sequencer for MMCME2_ADV.
// Holds the MMCM in reset, walks NUM_ENTRIES table entries (one RMW each),
// then releases reset and waits for LOCKED.
// Optional feature: define MMCM_DRP_TIMEOUT_EN to bound the DRDY/LOCKED waits
// by TIMEOUT_CYCLES (err pulse + abort); otherwise waits are unbounded and err=0.
module mmcm_drp_reconfig
  import mmcm_drp_pkg::*;
#(
  parameter  int NUM_ENTRIES    = 8,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W          = idx_width(NUM_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [IDX_W-1:0]      tbl_idx,
  input  logic [DRP_ADDR_W-1:0] tbl_addr,
  input  logic [DRP_DATA_W-1:0] tbl_mask,
  input  logic [DRP_DATA_W-1:0] tbl_data,
  mmcm_drp_reconfig_if.master   drp
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  state_t                r_state;
  state_t                w_next;
  logic [IDX_W-1:0]      r_idx;
  logic [DRP_DATA_W-1:0] r_rdata;
  logic [DRP_DATA_W-1:0] w_merged;
  logic                  r_done;
  logic                  w_done_set;
  logic                  w_timeout;

  assign w_merged = (r_rdata & tbl_mask) | (tbl_data & ~tbl_mask);
  assign tbl_idx  = r_idx;
  assign done     = r_done;

  // State register.
  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and DRP/MMCM outputs decoded from the current state.
  // NOTE: every output gets a default first so no path holds a value, which would infer a latch.
  always_comb begin
    w_next       = r_state;
    w_done_set   = 1'b0;
    busy         = (r_state != IDLE);
    drp.den      = 1'b0;
    drp.dwe      = 1'b0;
    drp.daddr    = '0;
    drp.di       = '0;
    drp.mmcm_rst = 1'b0;
    case (r_state)
      IDLE:      if (start) w_next = RST_ON;
      RST_ON: begin
        drp.mmcm_rst = 1'b1;
        w_next       = RD_REQ;
      end
      RD_REQ: begin
        drp.mmcm_rst = 1'b1;
        drp.den      = 1'b1;
        drp.daddr    = tbl_addr;
        w_next       = RD_WAIT;
      end
      RD_WAIT: begin
        drp.mmcm_rst = 1'b1;
        if (drp.drdy) w_next = WR_REQ;
      end
      WR_REQ: begin
        drp.mmcm_rst = 1'b1;
        drp.den      = 1'b1;
        drp.dwe      = 1'b1;
        drp.daddr    = tbl_addr;
        drp.di       = w_merged;
        w_next       = WR_WAIT;
      end
      WR_WAIT: begin
        drp.mmcm_rst = 1'b1;
        if (drp.drdy) w_next = NEXT;
      end
      NEXT: begin
        drp.mmcm_rst = 1'b1;
        w_next       = (r_idx == LAST_IDX) ? LOCK_WAIT : RD_REQ;
      end
      LOCK_WAIT: begin
        if (drp.locked) begin
          w_next     = IDLE;
          w_done_set = 1'b1;
        end
      end
      default:   w_next = IDLE;
    endcase
    // An expired wait abandons the sequence; mmcm_rst drops with the return to IDLE.
    if (w_timeout) w_next = IDLE;
  end

  // Table index: cleared on an accepted start, advanced in NEXT until the last entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_idx <= '0;
    else if (r_state == IDLE && start)         r_idx <= '0;
    else if (r_state == NEXT && r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
  end

  // Read-back capture and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_done  <= 1'b0;
    end else begin
      if (r_state == RD_WAIT && drp.drdy) r_rdata <= drp.do_i;
      r_done <= w_done_set;
    end
  end

`ifdef MMCM_DRP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_waiting;
  logic             w_event;

  assign w_waiting = (r_state == RD_WAIT) || (r_state == WR_WAIT) || (r_state == LOCK_WAIT);
  assign w_event   = ((r_state == RD_WAIT || r_state == WR_WAIT) && drp.drdy)
                   || (r_state == LOCK_WAIT && drp.locked);
  assign w_timeout = w_waiting && !w_event && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err       = r_err;

  // Wait counter: restarts on every state change, counts while parked in a wait state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_cnt <= '0;
    else if (w_next != r_state || !w_waiting) r_cnt <= '0;
    else                                    r_cnt <= r_cnt + 1'b1;
  end

  // Abort pulse, coincident with the first IDLE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_timeout;
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// tb_mmcm_drp_reconfig: directed bench for the MMCM DRP sequencer with a
// one-entry instance (dut1) and an eight-entry instance (dut8), each fed by
// its own table ROM. Timeout scenarios follow MMCM_DRP_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_mmcm_drp_reconfig;
  import mmcm_drp_pkg::*;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // One-entry instance
  logic       start1, busy1, done1, err1;
  logic [0:0] idx1;
  drp_entry_t ent1;
  mmcm_drp_reconfig_if bus1 ();
  mmcm_drp_table #(.NUM_ENTRIES(1)) u_tbl1 (.idx(idx1), .entry(ent1));
  mmcm_drp_reconfig #(.NUM_ENTRIES(1), .TIMEOUT_CYCLES(TMO)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .err(err1),
    .tbl_idx(idx1), .tbl_addr(ent1.addr), .tbl_mask(ent1.mask), .tbl_data(ent1.data),
    .drp(bus1.master)
  );

  // Eight-entry instance
  logic       start8, busy8, done8, err8;
  logic [2:0] idx8;
  drp_entry_t ent8;
  mmcm_drp_reconfig_if bus8 ();
  mmcm_drp_table #(.NUM_ENTRIES(8)) u_tbl8 (.idx(idx8), .entry(ent8));
  mmcm_drp_reconfig #(.NUM_ENTRIES(8), .TIMEOUT_CYCLES(TMO)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8), .err(err8),
    .tbl_idx(idx8), .tbl_addr(ent8.addr), .tbl_mask(ent8.mask), .tbl_data(ent8.data),
    .drp(bus8.master)
  );

  // Hand-computed table expectations: DRP address, value the model returns, write data.
  logic [6:0]  exp_addr [8] = '{7'h08, 7'h09, 7'h14, 7'h15, 7'h16, 7'h18, 7'h19, 7'h4E};
  logic [15:0] rd_val   [8] = '{16'hFFFF, 16'h1234, 16'h0000, 16'hABCD, 16'hFFFF, 16'h5555, 16'h8000, 16'h0F0F};
  logic [15:0] exp_di   [8] = '{16'h1041, 16'h1000, 16'h0145, 16'hA800, 16'hC041, 16'h57E8, 16'hFC01, 16'h9F0F};

  // Passive monitors sampled on the falling edge.
  int   done1_cnt  = 0;
  int   done8_cnt  = 0;
  int   den8_pairs = 0;
  logic prev_den8  = 1'b0;
  always @(negedge clk) begin
    if (done1) done1_cnt <= done1_cnt + 1;
    if (done8) done8_cnt <= done8_cnt + 1;
    if (bus8.den && prev_den8) den8_pairs <= den8_pairs + 1;
    prev_den8 <= bus8.den;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until dut8 shows den, bounded.
  task automatic wait_den8(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus8.den) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Return drdy dly cycles after the current den cycle, with read data rd.
  task automatic give_drdy8(input int dly, input logic [15:0] rd);
    for (int k = 0; k < dly; k++) tick();
    bus8.do_i = rd;
    bus8.drdy = 1'b1;
    tick();
    bus8.drdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy8, done8, err8, idx8, bus8.daddr, bus8.di, bus8.den, bus8.dwe, bus8.mmcm_rst} !== 32'h0) begin
      bad++;
      $display("FAIL reset_dut8: got busy=%b done=%b err=%b idx=%0d daddr=%h di=%h den=%b dwe=%b rst=%b want all 0",
               busy8, done8, err8, idx8, bus8.daddr, bus8.di, bus8.den, bus8.dwe, bus8.mmcm_rst);
    end
    total++;
    if ({busy1, done1, err1, idx1, bus1.daddr, bus1.di, bus1.den, bus1.dwe, bus1.mmcm_rst} !== 30'h0) begin
      bad++;
      $display("FAIL reset_dut1: got busy=%b done=%b err=%b den=%b rst=%b want all 0",
               busy1, done1, err1, bus1.den, bus1.mmcm_rst);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int d0;
    d0 = done1_cnt;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    total++;
    if ({busy1, bus1.mmcm_rst, bus1.den} !== 3'b110) begin
      bad++; $display("FAIL single_rst_on: got busy/rst/den=%b want 110", {busy1, bus1.mmcm_rst, bus1.den});
    end
    tick();
    total++;
    if ({bus1.den, bus1.dwe, bus1.daddr} !== {2'b10, 7'h08}) begin
      bad++; $display("FAIL single_rd_req: got den=%b dwe=%b daddr=%h want 1 0 08", bus1.den, bus1.dwe, bus1.daddr);
    end
    tick();
    total++;
    if ({bus1.den, bus1.mmcm_rst} !== 2'b01) begin
      bad++; $display("FAIL single_rd_wait: got den=%b rst=%b want 0 1", bus1.den, bus1.mmcm_rst);
    end
    bus1.do_i = 16'hFFFF;
    bus1.drdy = 1'b1;
    tick();
    bus1.drdy = 1'b0;
    total++;
    if ({bus1.den, bus1.dwe, bus1.daddr, bus1.di} !== {2'b11, 7'h08, 16'h1041}) begin
      bad++; $display("FAIL single_wr_req: got den=%b dwe=%b daddr=%h di=%h want 1 1 08 1041", bus1.den, bus1.dwe, bus1.daddr, bus1.di);
    end
    tick();
    bus1.drdy = 1'b1;
    tick();
    bus1.drdy = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({busy1, bus1.mmcm_rst, done1} !== 3'b100) begin
        bad++; $display("FAIL single_lock_wait[%0d]: got busy/rst/done=%b want 100", k, {busy1, bus1.mmcm_rst, done1});
      end
      if (k == 0) tick();
    end
    bus1.locked = 1'b1;
    tick();
    bus1.locked = 1'b0;
    total++;
    if ({done1, busy1} !== 2'b10) begin
      bad++; $display("FAIL single_done: got done=%b busy=%b want 1 0", done1, busy1);
    end
    tick();
    total++;
    if (done1 !== 1'b0 || (done1_cnt - d0) != 1) begin
      bad++; $display("FAIL single_done_once: got done=%b pulses=%0d want 0 1", done1, done1_cnt - d0);
    end
  endtask

  task automatic test_full_table();
    bit seen;
    int dens;
    int p0;
    dens = 0;
    p0 = den8_pairs;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_den8(seen);
      if (seen) dens++;
      total++;
      if (!seen || {bus8.dwe, bus8.daddr, idx8, bus8.mmcm_rst} !== {1'b0, exp_addr[i], 3'(i), 1'b1}) begin
        bad++; $display("FAIL full_rd[%0d]: got den=%b dwe=%b daddr=%h idx=%0d rst=%b want 1 0 %h %0d 1",
                        i, bus8.den, bus8.dwe, bus8.daddr, idx8, bus8.mmcm_rst, exp_addr[i], i);
      end
      give_drdy8(3, rd_val[i]);
      wait_den8(seen);
      if (seen) dens++;
      total++;
      if (!seen || {bus8.dwe, bus8.daddr, bus8.di, idx8, bus8.mmcm_rst} !== {1'b1, exp_addr[i], exp_di[i], 3'(i), 1'b1}) begin
        bad++; $display("FAIL full_wr[%0d]: got den=%b dwe=%b daddr=%h di=%h idx=%0d rst=%b want 1 1 %h %h %0d 1",
                        i, bus8.den, bus8.dwe, bus8.daddr, bus8.di, idx8, bus8.mmcm_rst, exp_addr[i], exp_di[i], i);
      end
      give_drdy8(3, 16'h0000);
    end
    tick();
    total++;
    if ({busy8, bus8.mmcm_rst} !== 2'b10) begin
      bad++; $display("FAIL full_lock_wait: got busy=%b rst=%b want 1 0", busy8, bus8.mmcm_rst);
    end
    bus8.locked = 1'b1;
    tick();
    bus8.locked = 1'b0;
    total++;
    if ({done8, busy8} !== 2'b10) begin
      bad++; $display("FAIL full_done: got done=%b busy=%b want 1 0", done8, busy8);
    end
    tick();
    total++;
    if (dens != 16 || den8_pairs != p0) begin
      bad++; $display("FAIL full_den_count: got pulses=%0d back_to_back=%0d want 16 0", dens, den8_pairs - p0);
    end
  endtask

  task automatic test_stray_inputs();
    bit seen;
    int d0;
    d0 = done8_cnt;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_den8(seen);
    // drdy coincident with the read den, plus a stray start
    bus8.drdy = 1'b1;
    start8 = 1'b1;
    tick();
    bus8.drdy = 1'b0;
    start8 = 1'b0;
    tick();
    total++;
    if ({bus8.den, busy8, bus8.mmcm_rst} !== 3'b011) begin
      bad++; $display("FAIL stray_early_drdy: got den=%b busy=%b rst=%b want 0 1 1", bus8.den, busy8, bus8.mmcm_rst);
    end
    bus8.do_i = 16'h0000;
    bus8.drdy = 1'b1;
    tick();
    bus8.drdy = 1'b0;
    wait_den8(seen);
    give_drdy8(1, 16'h0000);
    for (int i = 1; i < 8; i++) begin
      wait_den8(seen);
      start8 = (i == 4);
      give_drdy8(1, rd_val[i]);
      start8 = 1'b0;
      wait_den8(seen);
      give_drdy8(1, 16'h0000);
    end
    tick();
    // LOCK_WAIT: spurious drdy and start
    bus8.drdy = 1'b1;
    start8 = 1'b1;
    tick();
    bus8.drdy = 1'b0;
    start8 = 1'b0;
    tick();
    total++;
    if ({busy8, bus8.mmcm_rst, done8, idx8} !== {3'b100, 3'd7}) begin
      bad++; $display("FAIL stray_lock_wait: got busy=%b rst=%b done=%b idx=%0d want 1 0 0 7", busy8, bus8.mmcm_rst, done8, idx8);
    end
    bus8.locked = 1'b1;
    tick();
    bus8.locked = 1'b0;
    repeat (3) tick();
    total++;
    if (busy8 !== 1'b0 || (done8_cnt - d0) != 1) begin
      bad++; $display("FAIL stray_one_done: got busy=%b pulses=%0d want 0 1", busy8, done8_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_walk();
    bit seen;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_den8(seen);
      give_drdy8(1, rd_val[i]);
      wait_den8(seen);
      give_drdy8(1, 16'h0000);
    end
    wait_den8(seen);
    give_drdy8(1, rd_val[3]);
    wait_den8(seen);
    tick();
    total++;
    if ({busy8, bus8.mmcm_rst, bus8.den, idx8} !== {3'b110, 3'd3}) begin
      bad++; $display("FAIL midrst_pre: got busy=%b rst=%b den=%b idx=%0d want 1 1 0 3", busy8, bus8.mmcm_rst, bus8.den, idx8);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy8, done8, err8, idx8, bus8.daddr, bus8.di, bus8.den, bus8.dwe, bus8.mmcm_rst} !== 32'h0) begin
      bad++; $display("FAIL midrst_outputs: got busy=%b idx=%0d daddr=%h di=%h den=%b dwe=%b rst=%b want all 0",
                      busy8, idx8, bus8.daddr, bus8.di, bus8.den, bus8.dwe, bus8.mmcm_rst);
    end
    tick();
    rst = 1'b0;
    tick();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    total++;
    if ({bus8.den, bus8.dwe, bus8.daddr, idx8, bus8.mmcm_rst} !== {2'b10, 7'h08, 3'd0, 1'b1}) begin
      bad++; $display("FAIL midrst_restart: got den=%b dwe=%b daddr=%h idx=%0d rst=%b want 1 0 08 0 1",
                      bus8.den, bus8.dwe, bus8.daddr, idx8, bus8.mmcm_rst);
    end
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

`ifdef MMCM_DRP_TIMEOUT_EN
  task automatic test_drdy_timeout();
    bit seen;
    int d0;
    d0 = done8_cnt;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_den8(seen);
    tick();
    for (int k = 1; k < TMO; k++) begin
      tick();
      total++;
      if ({err8, busy8} !== 2'b01) begin
        bad++; $display("FAIL drdy_tmo_early[%0d]: got err=%b busy=%b want 0 1", k, err8, busy8);
      end
    end
    tick();
    total++;
    if ({err8, busy8, bus8.mmcm_rst, done8} !== 4'b1000) begin
      bad++; $display("FAIL drdy_tmo: got err=%b busy=%b rst=%b done=%b want 1 0 0 0", err8, busy8, bus8.mmcm_rst, done8);
    end
    tick();
    total++;
    if (err8 !== 1'b0 || done8_cnt != d0) begin
      bad++; $display("FAIL drdy_tmo_after: got err=%b pulses=%0d want 0 0", err8, done8_cnt - d0);
    end
  endtask
`endif

  task automatic test_lock_timeout();
    int d0;
    d0 = done1_cnt;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    bus1.drdy = 1'b1;
    tick();
    bus1.drdy = 1'b0;
    tick();
    bus1.drdy = 1'b1;
    tick();
    bus1.drdy = 1'b0;
    tick();
`ifdef MMCM_DRP_TIMEOUT_EN
    for (int k = 1; k < TMO; k++) begin
      tick();
      total++;
      if ({err1, busy1} !== 2'b01) begin
        bad++; $display("FAIL lock_tmo_early[%0d]: got err=%b busy=%b want 0 1", k, err1, busy1);
      end
    end
    tick();
    total++;
    if ({err1, busy1, bus1.mmcm_rst, done1} !== 4'b1000 || done1_cnt != d0) begin
      bad++; $display("FAIL lock_tmo: got err=%b busy=%b rst=%b done=%b pulses=%0d want 1 0 0 0 0",
                      err1, busy1, bus1.mmcm_rst, done1, done1_cnt - d0);
    end
`else
    begin
      int stuck_bad;
      stuck_bad = 0;
      for (int k = 0; k < 10000; k++) begin
        tick();
        if (busy1 !== 1'b1 || bus1.mmcm_rst !== 1'b0 || err1 !== 1'b0 || done1 !== 1'b0) stuck_bad++;
      end
      total++;
      if (stuck_bad != 0) begin
        bad++; $display("FAIL lock_hold: got %0d bad cycles want 0", stuck_bad);
      end
      bus1.locked = 1'b1;
      tick();
      bus1.locked = 1'b0;
      total++;
      if ({done1, busy1, err1} !== 3'b100 || (done1_cnt - d0) != 0) begin
        bad++; $display("FAIL lock_release: got done=%b busy=%b err=%b want 1 0 0", done1, busy1, err1);
      end
    end
`endif
  endtask

  initial begin
    start1 = 1'b0;
    start8 = 1'b0;
    bus1.do_i = '0;
    bus1.drdy = 1'b0;
    bus1.locked = 1'b0;
    bus8.do_i = '0;
    bus8.drdy = 1'b0;
    bus8.locked = 1'b0;
    test_reset();
    test_single();
    test_full_table();
    test_stray_inputs();
    test_reset_mid_walk();
`ifdef MMCM_DRP_TIMEOUT_EN
    test_drdy_timeout();
`endif
    test_lock_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
